// File: rtl/stc_egress_arbiter_serializer_pkg.sv
// Shared constants for the STC egress arbiter/serializer: tag nibble, FSM
// encoding and width helpers.
package stc_egress_pkg;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // bytes per complex word (re and im components together)
  function automatic int bytes_of(input int dw);
    return (2 * dw) / 8;
  endfunction

endpackage

// File: rtl/stc_egress_arbiter_serializer_if.sv
// Lane input bus, egress byte stream and status for the egress arbiter.
interface stc_egress_arbiter_serializer_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_CH*2*DATA_WIDTH-1:0] InData;
  logic [NUM_CH-1:0]              InValid;
  logic [7:0]                     ED;
  logic                           EValid;
  logic                           EReady;
  logic [NUM_CH-1:0]              Ovf;
  logic                           OvfClr;
  logic                           Busy;

  // producer/sink side
  modport master (output InData, InValid, EReady, OvfClr,
                  input  ED, EValid, Ovf, Busy);
  // block side
  modport slave  (input  InData, InValid, EReady, OvfClr,
                  output ED, EValid, Ovf, Busy);
endinterface

// File: rtl/stc_egress_arbiter_serializer_fifo.sv
// Per-lane synchronous FIFO. Head word is visible on dout before the pop;
// full/empty are registered so the arbiter sees clean flags.
module stc_sync_fifo
  import stc_egress_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout    = mem[rd_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // storage write, no reset needed on payload
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  // pointers, occupancy and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end
endmodule

// File: rtl/stc_egress_arbiter_serializer.sv
// Egress stage: per-lane FIFOs, round-robin arbiter, optional tag byte and
// MSB-first byte serializer with registered ED/EValid and sticky overflow.
module stc_egress_arbiter_serializer
  import stc_egress_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int HEADER_EN  = 1
) (
  input logic                           Clk,
  input logic                           ARst,
  stc_egress_arbiter_serializer_if.slave bus
);
  localparam int WW    = 2 * DATA_WIDTH;
  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int IW    = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int CW    = (BYTES > 1) ? clog2(BYTES) : 1;

  logic [NUM_CH-1:0]           full, empty, pop;
  logic [NUM_CH-1:0][WW-1:0]   dout;

  state_t                      state_q, state_d;
  logic [IW-1:0]               rr_q, rr_d, gnt;
  logic                        gnt_vld;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BYTES-1:0][7:0]       shift_q, shift_d;
  logic [7:0]                  ed_q, ed_d;
  logic                        ev_q, ev_d;
  logic [NUM_CH-1:0]           ovf_q, ovf_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    stc_sync_fifo #(.DW(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (Clk),
      .rst  (ARst),
      .push (bus.InValid[g]),
      .pop  (pop[g]),
      .din  (bus.InData[g*WW +: WW]),
      .dout (dout[g]),
      .full (full[g]),
      .empty(empty[g])
    );
  end

  // round-robin search rr+1 .. rr+NUM_CH; descending loop so the nearest lane wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IW'(idx);
      end
    end
  end

  // serializer FSM; ED/EValid next values computed here and registered below
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ed_d    = ed_q;
    ev_d    = ev_q;
    pop     = '0;
    case (state_q)
      ST_IDLE: begin
        ev_d = 1'b0;
        if (gnt_vld) begin
          pop[gnt] = 1'b1;
          shift_d  = dout[gnt];
          rr_d     = gnt;
          cnt_d    = CW'(BYTES - 1);
          ev_d     = 1'b1;
          if (HEADER_EN != 0) begin
            state_d = ST_HDR;
            ed_d    = {HDR_TAG, 4'(gnt)};
          end else begin
            state_d = ST_DATA;
            ed_d    = dout[gnt][WW-1 -: 8];
          end
        end
      end
      ST_HDR: begin
        if (bus.EReady) begin
          state_d = ST_DATA;
          ed_d    = shift_q[cnt_q];
        end
      end
      ST_DATA: begin
        if (bus.EReady) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            ev_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
            ed_d  = shift_q[cnt_q - CW'(1)];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ev_d    = 1'b0;
      end
    endcase
  end

  // a dropped push sets the bit even if a clear arrives in the same cycle
  assign ovf_d = (ovf_q & {NUM_CH{~bus.OvfClr}}) | (bus.InValid & full);

  // state, datapath and status registers
  always_ff @(posedge Clk) begin
    if (ARst) begin
      state_q <= ST_IDLE;
      rr_q    <= IW'(NUM_CH - 1);
      cnt_q   <= '0;
      shift_q <= '0;
      ed_q    <= '0;
      ev_q    <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ed_q    <= ed_d;
      ev_q    <= ev_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ED     = ed_q;
  assign bus.EValid = ev_q;
  assign bus.Ovf    = ovf_q;
  assign bus.Busy   = (state_q != ST_IDLE) | ~(&empty);
endmodule
